result_collector: RTL
=====================

Name: result_collector

Overview:
- Receiving end of the systolic array's skewed row interface.
- Each array row r presents valid/data r cycles after row r-1.
- The block de-skews the rows, packs one aligned column of partial sums into a single word and writes it to the result buffer SRAM at a sequential address.
- It signals completion after a configured number of pixels, and is the mirror of the west-side weight scheduler.

Parameters:
- ROWS, 8 (MATRIX_A_ROW): number of array rows/result lanes.
- ACC_WIDTH, 32: width of one accumulated result lane.
- ADDR_W, 10 (SRAM_ADDR_W): result buffer address width.

Ports:
- clk_i  in  1  single clock.
- rst_async_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  layer active; low flushes and idles the block.
- cfg_num_pix_i  in  ADDR_W+1  pixels (result words) expected per layer, legal 1..2^ADDR_W.
- east_valid_i  in  ROWS  per-row result valid, skewed (row r lags row 0 by r cycles).
- east_data_i  in  ROWS x ACC_WIDTH  per-row result data.
- rb_wr_en_o  out  1  result buffer write strobe.
- rb_addr_o  out  ADDR_W  write address.
- rb_data_o  out  ROWS x ACC_WIDTH  packed word; lane r = row r.
- done_o  out  1  one-cycle pulse on the final write.
- err_o  out  1  sticky skew-misalignment flag.

Behaviour:
- Reset: all outputs 0; delay lines cleared; state IDLE; address counter 0; pixel counter 0.
- De-skew:
  - Row r passes through ROWS-1-r delay stages, then a common output register.
  - Row ROWS-1 has zero delay stages before the register.
  - Delay stages advance only while enable_i=1.
- Latency: if row 0 is valid at cycle T with correct skew, rb_wr_en_o=1 at cycle T+ROWS, carrying all lanes of that column.
- FSM:
  - IDLE: enable_i=1 -> COLLECT, with addr=0 and count=0.
  - COLLECT: each aligned all-ones valid vector issues a write, addr+1, count+1. The write with count==cfg_num_pix_i-1 also pulses done_o and moves to DONE.
  - DONE: writes are blocked and further valids are ignored. enable_i=0 -> IDLE.
- Alignment check:
  - After de-skew, the vector must be all-ones or all-zeros.
  - A mixed vector sets err_o (sticky until reset or enable_i falling edge) and suppresses the write. addr and count do not advance.
- Address: increments by 1 per write. At 2^ADDR_W-1 it wraps to 0; this is only reachable when cfg_num_pix_i = 2^ADDR_W.
- rb_data_o is held at its last value when rb_wr_en_o=0; only rb_wr_en_o qualifies it.
- enable_i falling mid-COLLECT: on the next edge, state=IDLE, delay lines cleared, addr/count=0, err_o cleared, no further writes. In-flight data is discarded.
- enable_i re-asserted in the same cycle as DONE entry: DONE still holds until enable_i is seen low.
- Simultaneous final write and misalignment: the error wins. No write, no done_o.
- Counters: count is ADDR_W+1 bits; comparison is unsigned. cfg_num_pix_i is sampled continuously and must be stable while enable_i=1.

Decomposition:
- Shared package: ROWS/ACC_WIDTH/ADDR_W defaults from the existing definitions; a collector_state_e enum {IDLE, COLLECT, DONE}.
- One sub-module: deskew_line (parameterised depth, width; valid+data shift register with enable and clear, depth 0 = wire), instantiated per row under generate.

Test Plan:
- Ideal skew, ROWS=8, cfg_num_pix_i=4, row r data = 100*r+pixel: exactly 4 writes at addr 0..3, each starting 8 cycles after its row-0 valid, lane r=100*r+p, done_o on the 4th write only.
- Gapped stream: pixel 0, two idle cycles, pixels 1-2 -> writes at addr 0,1,2 with the same gaps and no spurious writes.
- Row 3 valid one cycle late for pixel 1 -> err_o=1 from the detection cycle; no write for pixel 1; addr does not advance; err_o stays high.
- enable_i dropped after 2 of 5 pixels -> no further writes; next enable restarts at addr 0 with err_o=0; full 5-pixel run then completes normally.
- cfg_num_pix_i=2 with 3 pixels streamed -> writes at addr 0,1, done_o with addr 1, 3rd pixel ignored; state held until enable_i=0.
- Reset asserted mid-COLLECT -> all outputs 0 immediately; no write on the following edges.

Source files
------------

// File: rtl/result_collector_pkg.sv
// result_collector_pkg: shared sizing defaults and FSM state type for the result collector.
package result_collector_pkg;
  localparam int ROWS      = 8;
  localparam int ACC_WIDTH = 32;
  localparam int ADDR_W    = 10;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} collector_state_e;
endpackage

// File: rtl/result_collector_deskew_line.sv
// deskew_line: valid+data shift register with enable and clear; depth 0 is a plain wire.
module deskew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_async_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_async_n_i, en_i, clr_i};
    assign valid_o   = valid_i;
    assign data_o    = data_i;
  end else begin : g_pipe
    logic [DEPTH-1:0]        v_q;
    logic [DEPTH-1:0][W-1:0] d_q;
    always_ff @(posedge clk_i or negedge rst_async_n_i)
      if (!rst_async_n_i) begin
        v_q <= '0;
        d_q <= '0;
      end else if (clr_i) begin
        v_q <= '0;
        d_q <= '0;
      end else if (en_i) begin
        v_q <= DEPTH'({v_q, valid_i});
        d_q <= (DEPTH*W)'({d_q, data_i});
      end
    assign valid_o = v_q[DEPTH-1];
    assign data_o  = d_q[DEPTH-1];
  end
endmodule

// File: rtl/result_collector.sv
// result_collector: de-skews the systolic array's east rows and writes aligned columns to the result buffer.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int ROWS      = result_collector_pkg::ROWS,
  parameter int ACC_WIDTH = result_collector_pkg::ACC_WIDTH,
  parameter int ADDR_W    = result_collector_pkg::ADDR_W
) (
  input  logic                               clk_i,
  input  logic                               rst_async_n_i,
  input  logic                               enable_i,
  input  logic [ADDR_W:0]                    cfg_num_pix_i,
  input  logic [ROWS-1:0]                    east_valid_i,
  input  logic [ROWS-1:0][ACC_WIDTH-1:0]     east_data_i,
  output logic                               rb_wr_en_o,
  output logic [ADDR_W-1:0]                  rb_addr_o,
  output logic [ROWS-1:0][ACC_WIDTH-1:0]     rb_data_o,
  output logic                               done_o,
  output logic                               err_o
);
  logic [ROWS-1:0]                al_v;
  logic [ROWS-1:0][ACC_WIDTH-1:0] al_d;
  collector_state_e               state_q;
  logic [ADDR_W-1:0]              addr_q, rb_addr_q;
  logic [ADDR_W:0]                cnt_q;
  logic [ROWS-1:0][ACC_WIDTH-1:0] data_q;
  logic                           wr_q, done_q, err_q;
  logic                           all_v, mixed_v, last;

  // row r lags row 0 by r cycles, so it needs ROWS-1-r stages to line up with the last row
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    deskew_line #(.DEPTH(ROWS-1-r), .W(ACC_WIDTH)) u_line (
      .clk_i         (clk_i),
      .rst_async_n_i (rst_async_n_i),
      .en_i          (enable_i),
      .clr_i         (!enable_i),
      .valid_i       (east_valid_i[r]),
      .data_i        (east_data_i[r]),
      .valid_o       (al_v[r]),
      .data_o        (al_d[r])
    );
  end

  assign all_v   = &al_v;
  assign mixed_v = |al_v && !all_v;
  assign last    = (cnt_q + 1'b1) == cfg_num_pix_i;

  always_ff @(posedge clk_i or negedge rst_async_n_i)
    if (!rst_async_n_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rb_addr_q <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      if (!enable_i) begin
        state_q   <= IDLE;
        addr_q    <= '0;
        cnt_q     <= '0;
        rb_addr_q <= '0;
        err_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= COLLECT;
            addr_q  <= '0;
            cnt_q   <= '0;
          end
          COLLECT: begin
            // a misaligned column is dropped entirely, even if it would have been the last one
            if (mixed_v) err_q <= 1'b1;
            else if (all_v) begin
              wr_q      <= 1'b1;
              rb_addr_q <= addr_q;
              data_q    <= al_d;
              addr_q    <= addr_q + 1'b1;
              cnt_q     <= cnt_q + 1'b1;
              if (last) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end

  assign rb_wr_en_o = wr_q;
  assign rb_addr_o  = rb_addr_q;
  assign rb_data_o  = data_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
endmodule
